// File: rtl/ila_capture_ctrl.sv
// Capture sequencer for ila_core: arms, waits for a masked trigger, strobes a
// fixed number of samples into the core, then streams them out over valid/ready.
module ila_capture_ctrl #(
  parameter int DATA_W   = 8,
  parameter int BUFFER_W = 8,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                abort,
  input  logic                read_start,
  input  logic [DATA_W-1:0]   trig_value,
  input  logic [DATA_W-1:0]   trig_mask,
  input  logic [1:0]          trig_mode,
  input  logic [BUFFER_W-1:0] post_count,
  input  logic [DATA_W-1:0]   signal,
  output logic [DATA_W-1:0]   ila_signal,
  output logic                ila_trigger,
  output logic                ila_enabled,
  output logic                ila_rst_soft,
  output logic [BUFFER_W-1:0] ila_index,
  input  logic [BUFFER_W-1:0] ila_samples,
  input  logic [DATA_W-1:0]   ila_value,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_last,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state
);

  // Readout handshake: a beat transfers on a cycle where rd_valid & rd_ready;
  // rd_data/rd_last are stable while rd_valid is high and not yet accepted.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WAIT  = 3'd2,
    S_CAP   = 3'd3,
    S_DONE  = 3'd4,
    S_RIDX  = 3'd5,
    S_ROUT  = 3'd6
  } state_t;

  localparam logic [1:0]          LAT_LAST = 2'(RD_LAT - 1);
  localparam logic [BUFFER_W-1:0] ONE      = BUFFER_W'(1);

  state_t st, st_n;

  logic [DATA_W-1:0]   cfg_value, cfg_value_n;
  logic [DATA_W-1:0]   cfg_mask, cfg_mask_n;
  logic [1:0]          cfg_mode, cfg_mode_n;
  logic [BUFFER_W-1:0] cfg_count, cfg_count_n;
  logic [BUFFER_W-1:0] cnt, cnt_n;
  logic [1:0]          lat_cnt, lat_cnt_n;
  logic                prev_match, prev_match_n;
  logic [DATA_W-1:0]   sig_d;

  logic                trigger_n, enabled_n, rst_soft_n;
  logic [BUFFER_W-1:0] index_n;
  logic [DATA_W-1:0]   rd_data_n;
  logic                rd_valid_n, rd_last_n;

  logic match, changed, hit;

  assign match   = ((signal ^ cfg_value) & cfg_mask) == '0;
  assign changed = ((signal ^ sig_d) & cfg_mask) != '0;

  always_comb begin
    hit = 1'b0;
    case (cfg_mode)
      2'b00:   hit = match;
      2'b01:   hit = match & ~prev_match;
      2'b10:   hit = changed;
      default: hit = 1'b1;
    endcase
  end

  always_comb begin
    st_n         = st;
    cfg_value_n  = cfg_value;
    cfg_mask_n   = cfg_mask;
    cfg_mode_n   = cfg_mode;
    cfg_count_n  = cfg_count;
    cnt_n        = cnt;
    lat_cnt_n    = lat_cnt;
    prev_match_n = match;
    trigger_n    = ila_trigger;
    enabled_n    = ila_enabled;
    rst_soft_n   = 1'b0;
    index_n      = ila_index;
    rd_data_n    = rd_data;
    rd_valid_n   = rd_valid;
    rd_last_n    = rd_last;

    if (abort) begin
      st_n       = S_IDLE;
      trigger_n  = 1'b0;
      enabled_n  = 1'b0;
      rd_valid_n = 1'b0;
      rd_last_n  = 1'b0;
      index_n    = '0;
    end else begin
      case (st)
        S_IDLE, S_DONE: begin
          if (arm) begin
            cfg_value_n  = trig_value;
            cfg_mask_n   = trig_mask;
            cfg_mode_n   = trig_mode;
            cfg_count_n  = (post_count == '0) ? ONE : post_count;
            prev_match_n = 1'b1;
            rst_soft_n   = 1'b1;
            st_n         = S_CLEAR;
          end else if (st == S_DONE && read_start && ila_samples != '0) begin
            index_n   = '0;
            lat_cnt_n = '0;
            st_n      = S_RIDX;
          end
        end
        S_CLEAR: begin
          enabled_n = 1'b1;
          st_n      = S_WAIT;
        end
        S_WAIT: begin
          // ila_signal is the registered copy of signal, so the matching
          // sample lands in the core on the same edge as the first strobe.
          if (hit) begin
            trigger_n = 1'b1;
            cnt_n     = ONE;
            st_n      = S_CAP;
          end
        end
        S_CAP: begin
          if (cnt < cfg_count) begin
            trigger_n = 1'b1;
            cnt_n     = cnt + ONE;
          end else begin
            trigger_n = 1'b0;
            enabled_n = 1'b0;
            st_n      = S_DONE;
          end
        end
        S_RIDX: begin
          if (lat_cnt == LAT_LAST) begin
            rd_data_n  = ila_value;
            rd_valid_n = 1'b1;
            rd_last_n  = (ila_index == ila_samples - ONE);
            st_n       = S_ROUT;
          end else begin
            lat_cnt_n = lat_cnt + 2'd1;
          end
        end
        S_ROUT: begin
          if (rd_ready) begin
            rd_valid_n = 1'b0;
            rd_last_n  = 1'b0;
            if (rd_last) begin
              st_n = S_DONE;
            end else begin
              index_n   = ila_index + ONE;
              lat_cnt_n = '0;
              st_n      = S_RIDX;
            end
          end
        end
        default: st_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st           <= S_IDLE;
      cfg_value    <= '0;
      cfg_mask     <= '0;
      cfg_mode     <= '0;
      cfg_count    <= '0;
      cnt          <= '0;
      lat_cnt      <= '0;
      prev_match   <= 1'b0;
      sig_d        <= '0;
      ila_signal   <= '0;
      ila_trigger  <= 1'b0;
      ila_enabled  <= 1'b0;
      ila_rst_soft <= 1'b0;
      ila_index    <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      st           <= st_n;
      cfg_value    <= cfg_value_n;
      cfg_mask     <= cfg_mask_n;
      cfg_mode     <= cfg_mode_n;
      cfg_count    <= cfg_count_n;
      cnt          <= cnt_n;
      lat_cnt      <= lat_cnt_n;
      prev_match   <= prev_match_n;
      sig_d        <= signal;
      ila_signal   <= signal;
      ila_trigger  <= trigger_n;
      ila_enabled  <= enabled_n;
      ila_rst_soft <= rst_soft_n;
      ila_index    <= index_n;
      rd_data      <= rd_data_n;
      rd_valid     <= rd_valid_n;
      rd_last      <= rd_last_n;
      busy         <= !(st_n == S_IDLE || st_n == S_DONE);
      done         <= (st_n == S_DONE);
    end
  end

  assign state = st;

endmodule
